// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl: bit-serial adder sequencer.
//   Adds two WIDTH-bit operands LSB first, one bit per clock, through a single
//   fulladder cell and a carry flop. The requester sees a start/busy/done
//   handshake.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, adds input `sub`. sub=1 selects op_a - op_b: B is captured
//   inverted, the carry flop is preset to 1 and cin is ignored.
//   cout=1 then means no borrow.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled only in IDLE
//   op_a   in   WIDTH  operand A, captured on accepted start
//   op_b   in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   sub    in   1      subtract select (SERIAL_ADD_SUB_EN only)
//   busy   out  1      high while operating
//   done   out  1      one-cycle pulse; sum/cout valid
//   sum    out  WIDTH  result, held until the next accepted start
//   cout   out  1      final carry, held like sum
// ---------------------------------------------------------------------------

// One-bit full adder cell: x is the sum bit, y is the carry out.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);
    assign x = a ^ b ^ c;
    assign y = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_x;
    logic             fa_y;

    // Capture values for B and the carry flop; subtract inverts B and forces carry-in.
    logic [WIDTH-1:0] b_cap;
    logic             carry_cap;
`ifdef SERIAL_ADD_SUB_EN
    assign b_cap     = sub ? ~op_b : op_b;
    assign carry_cap = sub ? 1'b1  : cin;
`else
    assign b_cap     = op_b;
    assign carry_cap = cin;
`endif

    fulladder u_fa (
        .a (a_q[0]),
        .b (b_q[0]),
        .c (carry_q),
        .x (fa_x),
        .y (fa_y)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = b_cap;
                    carry_d = carry_cap;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Concatenate-then-shift keeps the WIDTH=1 case free of empty slices.
                sum_d   = WIDTH'({fa_x, sum_q} >> 1);
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_y;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = fa_y;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
